// File: rtl/seg7_capture.sv
// seg7_capture: samples an 8-bit 7-segment bus (bit0 = a .. bit6 = g, bit7 = dp).
// A pattern qualifies once it has been stable for STABLE_CYCLES samples.
// Each new pattern is decoded back to a hex digit. Digits go to a consumer
// through a holding register plus a one-entry pending slot (valid/ready).
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples needed to qualify (2..255)
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   seg_in       segment bus, already synchronous to clk
//   out_data     decoded hex value (0 when out_invalid)
//   out_dp       captured decimal point
//   out_invalid  pattern not found in the decode table
//   out_valid    holding register holds an undelivered digit
//   out_ready    consumer accepts when out_valid && out_ready
//   out_overrun  sticky; a pending digit was overwritten before delivery
//   err_count    invalid digits delivered, saturating at 255
//                (present only when SEG7_CAPTURE_ERRCNT_EN is defined)
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    output logic [3:0] out_data,
    output logic       out_dp,
    output logic       out_invalid,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_overrun
`ifdef SEG7_CAPTURE_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int unsigned SEG_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_QUAL = CNT_W'(STABLE_CYCLES - 2);

    typedef struct packed {
        logic       dp;
        logic       invalid;
        logic [3:0] data;
    } digit_t;

    typedef enum logic {IDLE, HOLD} state_t;

    // Segment pattern to hex digit; unknown patterns decode to 0 with invalid set.
    function automatic digit_t decode(input logic [SEG_W-1:0] seg);
        digit_t d;
        d.dp      = seg[7];
        d.invalid = 1'b0;
        case (seg[6:0])
            7'h3F:   d.data = 4'h0;
            7'h06:   d.data = 4'h1;
            7'h5B:   d.data = 4'h2;
            7'h4F:   d.data = 4'h3;
            7'h66:   d.data = 4'h4;
            7'h6D:   d.data = 4'h5;
            7'h7D:   d.data = 4'h6;
            7'h07:   d.data = 4'h7;
            7'h7F:   d.data = 4'h8;
            7'h6F:   d.data = 4'h9;
            7'h77:   d.data = 4'hA;
            7'h7C:   d.data = 4'hB;
            7'h39:   d.data = 4'hC;
            7'h5E:   d.data = 4'hD;
            7'h79:   d.data = 4'hE;
            7'h71:   d.data = 4'hF;
            default: begin
                d.data    = 4'h0;
                d.invalid = 1'b1;
            end
        endcase
        return d;
    endfunction

    logic [SEG_W-1:0] seg_q;
    logic [CNT_W-1:0] stable_cnt;
    logic [SEG_W-1:0] last_acc;     // 0x00 doubles as "blank" since no digit has seg[6:0]==0
    logic             cand_valid;
    digit_t           cand;
    state_t           state;
    digit_t           pend;
    logic             pend_valid;

    logic qualify_c;
    logic blank_c;
    logic repeat_c;
    logic handshake_c;

    // Qualification fires only on the edge the counter reaches its saturation value.
    assign qualify_c   = (seg_in == seg_q) && (stable_cnt == CNT_QUAL);
    assign blank_c     = (seg_in[6:0] == 7'h00);
    assign repeat_c    = (seg_in == last_acc);
    assign handshake_c = out_valid && out_ready;

    // Sampler, stability counter and candidate stage (one cycle ahead of the buffer).
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            stable_cnt <= '0;
            last_acc   <= '0;
            cand_valid <= 1'b0;
            cand       <= '0;
        end else begin
            seg_q <= seg_in;
            if (seg_in != seg_q) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end

            cand_valid <= 1'b0;
            if (qualify_c) begin
                if (blank_c) begin
                    last_acc <= '0;
                end else if (!repeat_c) begin
                    cand_valid <= 1'b1;
                    cand       <= decode(seg_in);
                    last_acc   <= seg_in;
                end
            end
        end
    end

    // Output buffer: holding register (the outputs) plus one pending slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_dp      <= 1'b0;
            out_invalid <= 1'b0;
            out_data    <= '0;
            pend        <= '0;
            pend_valid  <= 1'b0;
            out_overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cand_valid) begin
                        {out_dp, out_invalid, out_data} <= cand;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (handshake_c) begin
                        if (pend_valid) begin
                            // Older pending digit goes first; a simultaneous candidate refills the slot.
                            {out_dp, out_invalid, out_data} <= pend;
                            pend_valid <= cand_valid;
                            if (cand_valid) begin
                                pend <= cand;
                            end
                        end else if (cand_valid) begin
                            {out_dp, out_invalid, out_data} <= cand;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (cand_valid) begin
                        if (pend_valid) begin
                            out_overrun <= 1'b1;
                        end
                        pend       <= cand;
                        pend_valid <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef SEG7_CAPTURE_ERRCNT_EN
    // Saturating count of invalid digits actually delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (handshake_c && out_invalid && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
